mem_access_unit: RTL
====================

# mem_access_unit

MEM-stage data-memory access controller: the consumer of the EX/MEM pipeline register outputs. It turns a memory instruction held in EX/MEM into a data-cache request (word address, byte enables, lane-shifted store data), holds the request until the cache responds, and stalls the pipeline meanwhile. It then delivers the lane-aligned, sign- or zero-extended load result to the MEM/WB path.

## Interface
- No parameters; widths are fixed at RV32.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset; state clears on a posedge where rst==0.
- valid_i  in  1  EX/MEM holds a live instruction.
- mem_read_i  in  1  the instruction is a load.
- mem_write_i  in  1  the instruction is a store.
- funct3_i  in  3  load/store width and sign code.
- addr_i  in  32  effective address (EX/MEM alu_out).
- wdata_i  in  32  store data (EX/MEM rs2_out).
- dmem_resp  in  1  cache completion, single-cycle pulse.
- dmem_rdata  in  32  cache read word; valid when dmem_resp=1.
- dmem_read  out  1  registered read request.
- dmem_write  out  1  registered write request.
- dmem_address  out  32  {addr[31:2],2'b00}, registered.
- dmem_wdata  out  32  lane-shifted store data, registered.
- dmem_byte_enable  out  4  byte lane mask, registered.
- stall_o  out  1  hold EX/MEM and all earlier stages; combinational.
- rdata_o  out  32  aligned and extended load data, registered.
- done_o  out  1  access complete this cycle; registered.
- misalign_o  out  1  misaligned access flagged; tied 0 unless MEM_MISALIGN_CHECK_EN.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- Request condition: req = valid_i & (mem_read_i | mem_write_i). If mem_read_i and mem_write_i are both 1, the instruction is treated as a read only.
- IDLE with req: latch address, funct3, op, byte enables and shifted wdata; go to ACCESS.
- ACCESS:
  - Hold dmem_read or dmem_write plus address/data/enables stable until dmem_resp.
  - On dmem_resp: capture the extended load result into rdata_o (stores leave rdata_o unchanged) and go to DONE.
- DONE: done_o=1; then go to IDLE unconditionally.
- Byte enables: SB = 4'b0001<<a; SH = 4'b0011<<a; SW = 4'b1111; reads = 4'b1111. Here a = addr[1:0] and the result is truncated to 4 bits. funct3 ≥ 3'b011 on a store uses the SW mask.
- Store data: wdata_i << (8*a), truncated to 32 bits.
- Load extract: w = dmem_rdata >> (8*a), then:
  - LB: sign-extend w[7:0]; LBU: zero-extend w[7:0].
  - LH: sign-extend w[15:0]; LHU: zero-extend w[15:0].
  - LW, and funct3 011/110/111: full word.
- stall_o = (state==IDLE & req) | (state==ACCESS); stall_o=0 in DONE and while rst==0.
- dmem_resp outside ACCESS is ignored.

## Timing
- Reset values: state=IDLE; dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable, rdata_o, done_o, misalign_o all 0.
- Cycle 0: IDLE, req=1, stall_o=1.
- Cycles 1..k: dmem_read/write=1. dmem_resp arrives in cycle k (k≥1).
- Cycle k+1: DONE. dmem_read/write=0, done_o=1, rdata_o valid, stall_o=0. EX/MEM advances at the end of this cycle.
- Minimum occupancy is 3 cycles (cache response in the first request cycle).
- A non-memory instruction (req=0) passes through IDLE with zero stall.
- Back-to-back memory instructions: the next one is seen in IDLE the cycle after DONE. The buffer still holds the old instruction during DONE, so valid_i there is ignored.
- rst low in any state, including mid-ACCESS: next cycle is IDLE with all outputs at reset values. The outstanding response is dropped.

## Configuration
- MEM_MISALIGN_CHECK_EN defined:
  - Misaligned accesses are LH/LHU/SH with a[0]=1, or LW/SW with a≠0.
  - From IDLE, a misaligned access goes directly to DONE with no dmem request, misalign_o=1 and done_o=1 for one cycle, and rdata_o=0.
- Not defined: misalign_o is tied 0. Accesses issue with truncated masks, e.g. SH at a=3 gives byte_enable 4'b1000.

## Structure
- rv32i_types carries the load_funct3_t/store_funct3_t enums (lb, lh, lw, lbu, lhu / sb, sh, sw), rv32i_word, and the mem_access_state_t enum.
- Sub-module load_align: combinational extractor of (dmem_rdata, a, funct3) to the 32-bit extended result.

## Test plan
- LB at addr 0x103, dmem_rdata 0x80FF_1234, resp in cycle 1 -> read mask 4'b1111, address 0x100, rdata_o 0xFFFF_FF80, done_o in cycle 2, stall_o high in cycles 0–1.
- SH at addr 0x22, wdata 0x0000_ABCD -> dmem_wdata 0xABCD_0000, byte_enable 4'b1100, address 0x20, held until resp arrives after 4 wait cycles.
- LHU at addr 0x2, rdata 0x8001_0000 -> rdata_o 0x0000_8001. LW in the next instruction starts the cycle after DONE.
- rst low during ACCESS with dmem_resp in the same cycle -> next cycle IDLE, dmem_read 0, rdata_o 0, done_o 0.
- SW at addr 0x6: with MEM_MISALIGN_CHECK_EN -> no dmem_write, misalign_o=1 and done_o=1 one cycle later. Without it -> dmem_write with byte_enable 4'b1111, address 0x4.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I types for the MEM-stage access unit: funct3 codes, data word,
// FSM states, and the byte-enable / misalignment helpers.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_access_state_t;

    // Shifted masks are truncated to 4 bits, so a half at offset 3 keeps only lane 3.
    function automatic logic [3:0] calc_byte_enable(input logic       is_read,
                                                    input logic [2:0] funct3,
                                                    input logic [1:0] offset);
        logic [3:0] be;
        be = 4'b1111;
        if (!is_read) begin
            case (funct3)
                sb:      be = 4'b0001 << offset;
                sh:      be = 4'b0011 << offset;
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    function automatic logic is_misaligned(input logic       is_read,
                                           input logic [2:0] funct3,
                                           input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        if (is_read) begin
            if ((funct3 == lh) || (funct3 == lhu)) bad = offset[0];
            else if (funct3 == lw)                 bad = (offset != 2'b00);
        end else begin
            if (funct3 == sh)      bad = offset[0];
            else if (funct3 == sw) bad = (offset != 2'b00);
        end
        return bad;
    endfunction

    function automatic rv32i_word shift_store_data(input rv32i_word  wdata,
                                                   input logic [1:0] offset);
        return wdata << {offset, 3'b000};
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Combinational load extractor: shifts the cache word down to the addressed
// lane and sign- or zero-extends it according to funct3.
module load_align
    import rv32i_types::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    rv32i_word shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        result  = shifted;
        case (funct3)
            lb:      result = {{24{shifted[7]}}, shifted[7:0]};
            lbu:     result = {24'h000000, shifted[7:0]};
            lh:      result = {{16{shifted[15]}}, shifted[15:0]};
            lhu:     result = {16'h0000, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: issues one cache request per
// EX/MEM memory instruction and stalls until it completes.
// Optional misalignment trap build: define MEM_MISALIGN_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for a load/store in EX/MEM; request latched on entry to ACCESS
// ACCESS | request held on the cache port until dmem_resp
// DONE   | result valid, done_o high, pipeline released for one cycle
module mem_access_unit
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        dmem_resp,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_enable,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        misalign_o
);

    mem_access_state_t state;

    logic       req;
    logic       req_is_read;
    logic       req_bad;
    logic       is_read_q;
    logic [1:0] offset_q;
    logic [2:0] funct3_q;
    rv32i_word  load_result;

    // A load+store encoding is treated as a load.
    assign req         = valid_i & (mem_read_i | mem_write_i);
    assign req_is_read = mem_read_i;

`ifdef MEM_MISALIGN_CHECK_EN
    logic misalign_q;

    assign req_bad    = is_misaligned(req_is_read, funct3_i, addr_i[1:0]);
    assign misalign_o = misalign_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else if ((state == IDLE) && req && req_bad) begin
            misalign_q <= 1'b1;
        end else if (state == DONE) begin
            misalign_q <= 1'b0;
        end
    end
`else
    assign req_bad    = 1'b0;
    assign misalign_o = 1'b0;
`endif

    assign stall_o = rst & (((state == IDLE) & req) | (state == ACCESS));

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .offset (offset_q),
        .funct3 (funct3_q),
        .result (load_result)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            is_read_q        <= 1'b0;
            offset_q         <= 2'b00;
            funct3_q         <= 3'b000;
            dmem_read        <= 1'b0;
            dmem_write       <= 1'b0;
            dmem_address     <= 32'h0000_0000;
            dmem_wdata       <= 32'h0000_0000;
            dmem_byte_enable <= 4'b0000;
            rdata_o          <= 32'h0000_0000;
            done_o           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        is_read_q    <= req_is_read;
                        offset_q     <= addr_i[1:0];
                        funct3_q     <= funct3_i;
                        dmem_address <= {addr_i[31:2], 2'b00};
                        if (req_bad) begin
                            // Trapped access: no cache traffic, result forced to zero.
                            rdata_o <= 32'h0000_0000;
                            done_o  <= 1'b1;
                            state   <= DONE;
                        end else begin
                            dmem_read        <= req_is_read;
                            dmem_write       <= ~req_is_read;
                            dmem_wdata       <= shift_store_data(wdata_i, addr_i[1:0]);
                            dmem_byte_enable <= calc_byte_enable(req_is_read, funct3_i,
                                                                 addr_i[1:0]);
                            state            <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (dmem_resp) begin
                        dmem_read  <= 1'b0;
                        dmem_write <= 1'b0;
                        if (is_read_q) begin
                            rdata_o <= load_result;
                        end
                        done_o <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    dmem_read  <= 1'b0;
                    dmem_write <= 1'b0;
                    done_o     <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
